// File: rtl/jpeg_quant_pkg.sv
// Shared widths, types and the default luminance reciprocal table for jpeg_quantizer.
// Table entries are round(2^16/Q) for the quality-50 luminance table, listed in zigzag order.
package jpeg_quant_pkg;

    localparam int COEF_W  = 12;
    localparam int OUT_W   = 11;
    localparam int RECIP_W = 17;
    localparam int PROD_W  = 28;
    localparam int IDX_W   = 6;

    typedef logic signed [COEF_W-1:0]  coef_t;
    typedef logic signed [OUT_W-1:0]   qcoef_t;
    typedef logic        [RECIP_W-1:0] recip_t;
    typedef logic        [PROD_W-1:0]  prod_t;
    typedef logic        [IDX_W-1:0]   idx_t;

    localparam qcoef_t QMAX = qcoef_t'(1023);
    localparam qcoef_t QMIN = qcoef_t'(-1024);

    localparam recip_t DEFAULT_RECIP [64] = '{
        17'd4096, 17'd5958, 17'd5461, 17'd4681, 17'd5461, 17'd6554, 17'd4096, 17'd4681,
        17'd5041, 17'd4681, 17'd3641, 17'd3855, 17'd4096, 17'd3449, 17'd2731, 17'd1638,
        17'd2521, 17'd2731, 17'd2979, 17'd2979, 17'd2731, 17'd1337, 17'd1872, 17'd1771,
        17'd2260, 17'd1638, 17'd1130, 17'd1285, 17'd1074, 17'd1092, 17'd1150, 17'd1285,
        17'd1170, 17'd1192, 17'd1024, 17'd910,  17'd712,  17'd840,  17'd1024, 17'd964,
        17'd753,  17'd950,  17'd1192, 17'd1170, 17'd819,  17'd601,  17'd809,  17'd753,
        17'd690,  17'd669,  17'd636,  17'd630,  17'd636,  17'd1057, 17'd851,  17'd580,
        17'd542,  17'd585,  17'd655,  17'd546,  17'd712,  17'd649,  17'd636,  17'd662
    };

endpackage

// File: rtl/jpeg_quant_mulrnd.sv
// Stages S1-S2 of the quantizer: magnitude x reciprocal, round half away from zero,
// reapply sign and saturate. Both stages advance only when en is high.
module jpeg_quant_mulrnd
    import jpeg_quant_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic signed [COEF_W-1:0]  in_coef,
    input  logic [RECIP_W-1:0]        in_recip,
    input  logic [IDX_W-1:0]          in_idx,
    output logic                      out_valid,
    output logic signed [OUT_W-1:0]   out_coef,
    output logic [IDX_W-1:0]          out_idx
);

    logic          s1_valid;
    prod_t         s1_prod;
    logic          s1_neg;
    idx_t          s1_idx;
    logic [11:0]   abs_coef;
    logic [11:0]   mag;
    qcoef_t        sat_coef;

    // -(-2048) wraps to 12'h800, which read as unsigned is the correct magnitude.
    assign abs_coef = in_coef[COEF_W-1] ? 12'(-in_coef) : 12'(in_coef);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: datapath registers skip reset; the valid bit alone says whether they mean anything.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_prod <= PROD_W'(abs_coef) * PROD_W'(in_recip);
            s1_neg  <= in_coef[COEF_W-1];
            s1_idx  <= in_idx;
        end
    end

    assign mag = 12'((s1_prod + prod_t'(32768)) >> 16);

    // NOTE: give every always_comb output a default first so no path can infer a latch.
    always_comb begin
        sat_coef = '0;
        if (s1_neg) begin
            sat_coef = (mag > 12'd1024) ? QMIN : qcoef_t'(-mag);
        end else begin
            sat_coef = (mag > 12'd1023) ? QMAX : qcoef_t'(mag);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_coef  <= '0;
            out_idx   <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            out_coef  <= sat_coef;
            out_idx   <= s1_idx;
        end
    end

endmodule

// File: rtl/jpeg_quantizer.sv
// JPEG coefficient quantizer: handshake, zigzag index counter, reciprocal table and S0.
// Define QTABLE_LOAD_EN to get a writable table (qt_* ports); otherwise the table is a ROM.
module jpeg_quantizer
    import jpeg_quant_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COEF_W-1:0]  in_coef,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   out_coef,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      out_eob
`ifdef QTABLE_LOAD_EN
    ,
    input  logic                      qt_we,
    input  logic [IDX_W-1:0]          qt_addr,
    input  logic [RECIP_W-1:0]        qt_data
`endif
);

    logic   adv;
    idx_t   idx_cnt;
    logic   s0_valid;
    coef_t  s0_coef;
    idx_t   s0_idx;
    recip_t s0_recip;

    // The whole pipeline moves together whenever the output slot is free or being drained.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign out_eob  = out_valid && (out_idx == idx_t'(63));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_cnt  <= '0;
            s0_valid <= 1'b0;
        end else if (adv) begin
            s0_valid <= in_valid;
            if (in_valid) begin
                idx_cnt <= idx_cnt + idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s0_coef <= in_coef;
            s0_idx  <= idx_cnt;
        end
    end

`ifdef QTABLE_LOAD_EN
    recip_t qtable [64];

    // A write lands at the edge, so a same-cycle S0 read of that entry still sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                qtable[i] <= DEFAULT_RECIP[i];
            end
        end else if (qt_we) begin
            qtable[qt_addr] <= qt_data;
        end
    end

    assign s0_recip = qtable[s0_idx];
`else
    assign s0_recip = DEFAULT_RECIP[s0_idx];
`endif

    jpeg_quant_mulrnd u_mulrnd (
        .clk       (clk),
        .rst       (rst),
        .en        (adv),
        .in_valid  (s0_valid),
        .in_coef   (s0_coef),
        .in_recip  (s0_recip),
        .in_idx    (s0_idx),
        .out_valid (out_valid),
        .out_coef  (out_coef),
        .out_idx   (out_idx)
    );

endmodule
